// File: rtl/i2c_reg_write_arbiter.sv
// i2c_reg_write_arbiter: round-robin sharing of the target's local write port, with host-write detection and lockout
module i2c_reg_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int HOLD_CYCLES = 16,
  localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
  localparam int HW = HOLD_CYCLES > 0 ? $clog2(HOLD_CYCLES + 1) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           reg_data_in,
  output logic                 reg_data_latch,
  input  logic [7:0]           reg_data_out,
  output logic                 host_wr_valid,
  output logic [7:0]           host_wr_data,
  output logic [GW-1:0]        grant_id,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, LATCH, VERIFY, HOLD} state_t;
  state_t state_q, state_d;
  logic [7:0] exp_q, exp_d, prev_q, hd_q;
  logic [GW-1:0] gnt_q, gnt_d, rr_q, rr_d, pick, nxt;
  logic [HW-1:0] hold_q, hold_d;
  logic primed_q, hv_q, change, own_change, host_change;
  assign change = primed_q && (reg_data_out != prev_q);
  assign own_change = change && state_q == VERIFY && reg_data_out == exp_q;
  assign host_change = change && !own_change;
  // Scan downwards so the lowest offset from rr_q wins.
  always_comb begin
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid[(int'(rr_q) + i) % NUM_REQ]) pick = GW'((int'(rr_q) + i) % NUM_REQ);
    nxt = GW'((int'(pick) + 1) % NUM_REQ);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      exp_q <= '0;
      gnt_q <= '0;
      rr_q <= '0;
      hold_q <= '0;
      prev_q <= '0;
      primed_q <= 1'b0;
      hv_q <= 1'b0;
      hd_q <= '0;
    end else begin
      state_q <= state_d;
      exp_q <= exp_d;
      gnt_q <= gnt_d;
      rr_q <= rr_d;
      hold_q <= hold_d;
      prev_q <= reg_data_out;
      primed_q <= 1'b1;
      hv_q <= host_change;
      hd_q <= host_change ? reg_data_out : hd_q;
    end
  always_comb begin
    state_d = state_q;
    exp_d = exp_q;
    gnt_d = gnt_q;
    rr_d = rr_q;
    hold_d = hold_q;
    if (host_change) begin
      state_d = HOLD_CYCLES == 0 ? IDLE : HOLD;
      hold_d = HW'(HOLD_CYCLES);
    end else begin
      case (state_q)
        IDLE: if (|req_valid) begin
          state_d = LATCH;
          exp_d = req_data[8*int'(pick) +: 8];
          gnt_d = pick;
          rr_d = nxt;
        end
        LATCH: state_d = VERIFY;
        VERIFY: state_d = IDLE;
        default: begin
          hold_d = hold_q - HW'(1);
          state_d = hold_q <= HW'(1) ? IDLE : HOLD;
        end
      endcase
    end
  end
  always_comb begin
    reg_data_latch = state_q == LATCH;
    req_ready = reg_data_latch ? NUM_REQ'(1) << gnt_q : '0;
    reg_data_in = exp_q;
    grant_id = gnt_q;
    busy = state_q != IDLE;
    host_wr_valid = hv_q;
    host_wr_data = hd_q;
  end
endmodule

// File: tb/tb_i2c_reg_write_arbiter.sv
// tb_i2c_reg_write_arbiter: directed checks of arbitration, own-write masking, host-write lockout and reset
module tb_i2c_reg_write_arbiter;
  logic clk = 0, rst = 0;
  logic [31:0] req_data = '0;
  logic [3:0] req_valid = '0, req_ready;
  logic [7:0] reg_data_in, reg_data_out, host_wr_data;
  logic reg_data_latch, host_wr_valid, busy;
  logic [1:0] grant_id;
  logic host_req = 0;
  logic [7:0] host_val = '0, tgt = '0;
  logic [7:0] rr_dat [4];
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  // Target register model: local latch beats a simultaneous host write.
  always @(posedge clk)
    if (reg_data_latch) tgt <= reg_data_in;
    else if (host_req) tgt <= host_val;
  assign reg_data_out = tgt;
  i2c_reg_write_arbiter dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .reg_data_in(reg_data_in), .reg_data_latch(reg_data_latch), .reg_data_out(reg_data_out),
    .host_wr_valid(host_wr_valid), .host_wr_data(host_wr_data), .grant_id(grant_id), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 0;
    tick();
    rst = 1;
    tick();
  endtask
  task automatic host_write(input logic [7:0] v);
    host_req = 1;
    host_val = v;
    tick();
    host_req = 0;
  endtask
  initial begin
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_latch", reg_data_latch, 0);
    check("rst_ready", req_ready, 0);
    check("rst_hv", host_wr_valid, 0);
    rst = 1;
    tick();
    check("idle_busy", busy, 0);
    // single write from requester 2
    req_data[23:16] = 8'hA5;
    req_valid = 4'b0100;
    tick();
    check("sw_latch", reg_data_latch, 1);
    check("sw_ready", req_ready, 32'h4);
    check("sw_din", reg_data_in, 8'hA5);
    check("sw_gid", grant_id, 2);
    check("sw_busy", busy, 1);
    req_valid = 0;
    tick();
    check("sw_busy2", busy, 1);
    check("sw_latch2", reg_data_latch, 0);
    check("sw_ready2", req_ready, 0);
    tick();
    check("sw_idle", busy, 0);
    check("sw_hv", host_wr_valid, 0);
    // round robin from rr_ptr=0
    do_reset();
    rr_dat = '{8'h00, 8'h22, 8'h33, 8'h44};
    req_data = {rr_dat[3], rr_dat[2], rr_dat[1], rr_dat[0]};
    req_valid = 4'hF;
    for (int c = 0; c <= 12; c++) begin
      tick();
      if (c % 3 == 0) begin
        check("rr_ready", req_ready, 32'(1) << ((c / 3) % 4));
        check("rr_gid", grant_id, (c / 3) % 4);
        check("rr_din", reg_data_in, rr_dat[(c / 3) % 4]);
      end else check("rr_noready", req_ready, 0);
      check("rr_hv", host_wr_valid, 0);
    end
    req_valid = 0;
    tick();
    tick();
    check("rr_idle", busy, 0);
    check("rr_tgt", reg_data_out, 8'h00);
    // host write 00->3C with a pending request on requester 0
    host_write(8'h3C);
    req_data[7:0] = 8'h99;
    req_valid = 4'b0001;
    check("hw_pre_busy", busy, 0);
    tick();
    check("hw_hv", host_wr_valid, 1);
    check("hw_hd", host_wr_data, 8'h3C);
    check("hw_busy", busy, 1);
    check("hw_ready", req_ready, 0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 1) check("hw_hv_once", host_wr_valid, 0);
      check("hw_hold_busy", busy, 1);
      check("hw_hold_ready", req_ready, 0);
    end
    tick();
    check("hw_idle", busy, 0);
    check("hw_idle_ready", req_ready, 0);
    tick();
    check("hw_grant", req_ready, 32'h1);
    check("hw_din", reg_data_in, 8'h99);
    req_valid = 0;
    tick();
    tick();
    check("hw_after_hv", host_wr_valid, 0);
    check("hw_after_busy", busy, 0);
    // second host write during HOLD at hold_cnt=5
    host_write(8'h3C);
    tick();
    check("hh_hv1", host_wr_valid, 1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) check("hh_hv1_once", host_wr_valid, 0);
    end
    host_write(8'h7E);
    tick();
    check("hh_hv2", host_wr_valid, 1);
    check("hh_hd2", host_wr_data, 8'h7E);
    check("hh_busy", busy, 1);
    for (int k = 13; k <= 27; k++) begin
      tick();
      if (k == 13) check("hh_hv2_once", host_wr_valid, 0);
      check("hh_hold_busy", busy, 1);
    end
    tick();
    check("hh_idle", busy, 0);
    // own write masking, then rewrite of the same value
    for (int r = 0; r < 2; r++) begin
      req_data[15:8] = 8'h55;
      req_valid = 4'b0010;
      tick();
      check("ow_ready", req_ready, 32'h2);
      check("ow_din", reg_data_in, 8'h55);
      req_valid = 0;
      tick();
      check("ow_tgt", reg_data_out, 8'h55);
      tick();
      check("ow_hv", host_wr_valid, 0);
      check("ow_busy", busy, 0);
    end
    // reset in the middle of HOLD
    host_write(8'h3C);
    tick();
    check("rh_hv", host_wr_valid, 1);
    for (int k = 1; k <= 8; k++) tick();
    check("rh_pre_busy", busy, 1);
    rst = 0;
    #1;
    check("rh_busy", busy, 0);
    check("rh_hd", host_wr_data, 0);
    check("rh_gid", grant_id, 0);
    check("rh_din", reg_data_in, 0);
    check("rh_hv0", host_wr_valid, 0);
    host_write(8'hA7);
    rst = 1;
    tick();
    check("rh_rel_hv", host_wr_valid, 0);
    check("rh_rel_busy", busy, 0);
    tick();
    check("rh_rel_hv2", host_wr_valid, 0);
    check("rh_rel_busy2", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_reg_write_arbiter.md
Name: i2c_reg_write_arbiter

Overview:
- Shares the local write port (data_in / data_latch) of the I2C single-register target between NUM_REQ on-chip requesters.
- Round-robin arbitration with a valid/ready handshake; one latch pulse per granted write.
- Watches the register read-back (data_out) to tell its own writes apart from writes made by the I2C host.
- On a host write: reports it, then locks out local writes for HOLD_CYCLES so host data is not clobbered immediately.

Parameters:
- NUM_REQ, 4, number of requesters (1..16)
- HOLD_CYCLES, 16, lockout length in clk cycles after a detected host write; 0 means no lockout

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- req_data  input  8*NUM_REQ  write data; requester i uses bits [8i+7:8i]
- req_valid  input  NUM_REQ  write request per requester
- req_ready  output  NUM_REQ  one-cycle accept pulse per requester
- reg_data_in  output  8  to target data_in
- reg_data_latch  output  1  to target data_latch
- reg_data_out  input  8  from target data_out
- host_wr_valid  output  1  one-cycle pulse: host write detected
- host_wr_data  output  8  value written by host; valid with host_wr_valid
- grant_id  output  clog2(NUM_REQ), min 1  index of the last granted requester
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; all outputs 0; rr_ptr=0; prev_data_out=0; hold_cnt=0; primed=0.
- Every cycle: prev_data_out <= reg_data_out.
- primed goes to 1 one cycle after reset deasserts. While primed=0, host-change detection is suppressed.
- change = primed && (reg_data_out != prev_data_out).
- own_change = change && state==VERIFY && reg_data_out==expected.
- host_change = change && !own_change.
- host_change response (highest priority), registered:
  - next cycle: host_wr_valid=1, host_wr_data=reg_data_out.
  - hold_cnt <= HOLD_CYCLES; state -> HOLD. If HOLD_CYCLES==0, state -> IDLE instead.
- IDLE:
  - Stays in IDLE if no req_valid or host_change is asserted.
  - Otherwise: g = first set req_valid at or after rr_ptr, wrapping modulo NUM_REQ.
  - Capture: expected <= req_data[g], grant_id <= g, rr_ptr <= (g+1) mod NUM_REQ; -> LATCH.
- LATCH (1 cycle), outputs registered:
  - reg_data_latch=1, reg_data_in=expected, req_ready[g]=1; -> VERIFY.
  - Requester data is sampled in the IDLE cycle, so the requester must hold data while valid.
  - The requester drops req_valid after seeing ready; no re-grant can occur before IDLE.
- VERIFY (1 cycle):
  - The target's data_out reflects the latch in this cycle; the own write is masked here.
  - -> IDLE, or -> HOLD on host_change.
  - A rewrite of the unchanged value produces no change and no false flag.
- HOLD:
  - hold_cnt decrements each cycle; at 0 -> IDLE. req_ready is never asserted in HOLD.
  - host_change during HOLD reloads hold_cnt and re-pulses host_wr_valid.
- Throughput: one local write per 3 cycles; request-to-ready latency is 1 cycle from IDLE.
- Host write and latch in the same cycle: the target's local latch wins and the host value is lost. This is a known limitation and goes undetected; the lockout window exists to narrow it.
- req_valid deasserted before ready: the write still completes with the captured data. Requesters must not withdraw requests.
- NUM_REQ=1: rr_ptr stays at 0; grant_id is 0.

Test Plan:
- Single write:
  - req_valid[2]=1, req_data[2]=8'hA5.
  - Expect: reg_data_latch and req_ready[2] pulse 1 cycle later; reg_data_in=A5; grant_id=2; no host_wr_valid; busy high 2 cycles.
- Round robin:
  - All 4 req_valid held high for 12 cycles.
  - Expect: grants in order 0,1,2,3 at 3-cycle spacing, then 0 again.
- Host write:
  - Force reg_data_out 00->3C with the arbiter idle.
  - Expect: host_wr_valid=1 with host_wr_data=3C for exactly 1 cycle.
  - A pending req_valid[0] is not granted until 16 cycles of HOLD have elapsed; ready arrives on the cycle after return to IDLE.
- Host write during HOLD:
  - Second change 3C->7E at hold_cnt=5.
  - Expect: second host_wr_valid pulse; hold restarts from 16.
- Own-write masking:
  - Local write of 8'h55, target echoes 55 in VERIFY → no host_wr_valid.
  - Local write of an equal value → no change, no flag.
- Reset mid-HOLD:
  - Drop rst at hold_cnt=8.
  - Expect: immediate IDLE with outputs 0.
  - Expect: no spurious host_wr_valid in the first cycle after release, even if reg_data_out is nonzero.
